// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit single-cycle processor:
// opcode constants, branch condition codes and ALU flag bit positions.
package isa_pkg;

  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    NEQ    = 3'b000,
    EQ     = 3'b001,
    GT     = 3'b010,
    LT     = 3'b011,
    GTE    = 3'b100,
    LTE    = 3'b101,
    OVFL   = 3'b110,
    UNCOND = 3'b111
  } cc_e;

endpackage

// File: rtl/pc_cond_eval.sv
// Branch condition evaluator: decides whether a condition code holds for
// the given {N, V, Z} flags. Purely combinational so it can be shared by
// the single-cycle and pipelined PC logic.
module pc_cond_eval
  import isa_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic w_n;
  logic w_v;
  logic w_z;

  assign w_n = flags[FLAG_N];
  assign w_v = flags[FLAG_V];
  assign w_z = flags[FLAG_Z];

  // Map each condition code onto its flag expression.
  always_comb begin
    taken = 1'b0;
    case (cc_e'(cond))
      NEQ:     taken = ~w_z;
      EQ:      taken = w_z;
      GT:      taken = ~w_z & ~w_n;
      LT:      taken = w_n;
      GTE:     taken = w_z | ~w_n;
      LTE:     taken = w_n | w_z;
      OVFL:    taken = w_v;
      UNCOND:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_control.sv
// Next-PC generator: picks sequential, PC-relative branch, register branch
// or halt address each cycle and registers it as the next fetch address.
// Optional macro PC_CONTROL_TAKEN_OUT_EN adds a combinational branch_taken
// output; the PC behaviour does not depend on it.
module pc_control
  import isa_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        flags,
  input  logic [ADDR_W-1:0] instruction,
  input  logic [ADDR_W-1:0] branch_reg_addr,
  input  logic [ADDR_W-1:0] pc_addr_in,
`ifdef PC_CONTROL_TAKEN_OUT_EN
  output logic              branch_taken,
`endif
  output logic [ADDR_W-1:0] pc_addr_out
);

  logic [3:0]        w_opcode;
  logic [2:0]        w_cond;
  logic              w_cond_true;
  logic              w_is_branch;
  logic [ADDR_W-1:0] w_pc_plus2;
  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_target_b;
  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] r_pc;

  assign w_opcode = instruction[15:12];
  assign w_cond   = instruction[11:9];

  pc_cond_eval u_cond_eval (
    .cond  (w_cond),
    .flags (flags),
    .taken (w_cond_true)
  );

  // Sequential and PC-relative targets; offset is a signed halfword count.
  always_comb begin
    w_pc_plus2 = pc_addr_in + 16'd2;
    w_offset   = {{6{instruction[8]}}, instruction[8:0], 1'b0};
    w_target_b = w_pc_plus2 + w_offset;
  end

  // Next-PC select: halt holds, taken branches jump, everything else steps.
  always_comb begin
    w_next_pc   = w_pc_plus2;
    w_is_branch = 1'b0;
    case (w_opcode)
      OP_HLT: begin
        w_next_pc = pc_addr_in;
      end
      OP_B: begin
        w_is_branch = 1'b1;
        if (w_cond_true) begin
          w_next_pc = w_target_b;
        end else begin
          w_next_pc = w_pc_plus2;
        end
      end
      OP_BR: begin
        w_is_branch = 1'b1;
        if (w_cond_true) begin
          w_next_pc = branch_reg_addr;
        end else begin
          w_next_pc = w_pc_plus2;
        end
      end
      default: begin
        w_next_pc = w_pc_plus2;
      end
    endcase
  end

  // PC register; reset wins over halt and branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  assign pc_addr_out = r_pc;

`ifdef PC_CONTROL_TAKEN_OUT_EN
  // Taken indication for the current instruction, masked during reset.
  always_comb begin
    branch_taken = w_is_branch & w_cond_true & ~rst;
  end
`else
  logic w_unused_branch;
  assign w_unused_branch = w_is_branch;
`endif

endmodule

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control: expected next-PC values are pushed
// to a scoreboard when stimulus is applied and compared after the edge.
module tb_pc_control;

  logic        clk;
  logic        rst;
  logic [2:0]  flags;
  logic [15:0] instruction;
  logic [15:0] branch_reg_addr;
  logic [15:0] pc_addr_in;
  logic [15:0] pc_addr_out;
`ifdef PC_CONTROL_TAKEN_OUT_EN
  logic        branch_taken;
`endif

  int n_tests;
  int n_fail;

  logic [15:0] sb_exp[$];
  string       sb_tag[$];

  pc_control dut (
    .clk             (clk),
    .rst             (rst),
    .flags           (flags),
    .instruction     (instruction),
    .branch_reg_addr (branch_reg_addr),
    .pc_addr_in      (pc_addr_in),
`ifdef PC_CONTROL_TAKEN_OUT_EN
    .branch_taken    (branch_taken),
`endif
    .pc_addr_out     (pc_addr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Condition table written directly from the ISA description.
  function automatic bit cond_true(input logic [2:0] c, input logic [2:0] f);
    bit n, v, z;
    n = f[2];
    v = f[1];
    z = f[0];
    case (c)
      3'd0:    return (z == 1'b0);
      3'd1:    return (z == 1'b1);
      3'd2:    return (z == 1'b0) && (n == 1'b0);
      3'd3:    return (n == 1'b1);
      3'd4:    return (z == 1'b1) || ((z == 1'b0) && (n == 1'b0));
      3'd5:    return (n == 1'b1) || (z == 1'b1);
      3'd6:    return (v == 1'b1);
      default: return 1'b1;
    endcase
  endfunction

  // Apply one cycle of stimulus, push the expectation, compare after the edge.
  task automatic step(input string tag, input logic r, input logic [15:0] ins,
                      input logic [15:0] pc, input logic [2:0] f,
                      input logic [15:0] br, input logic [15:0] exp);
    rst             = r;
    instruction     = ins;
    pc_addr_in      = pc;
    flags           = f;
    branch_reg_addr = br;
    sb_exp.push_back(exp);
    sb_tag.push_back(tag);
`ifdef PC_CONTROL_TAKEN_OUT_EN
    #1;
    check_eq({tag, "_taken"}, {15'd0, branch_taken},
             {15'd0, (!r && (ins[15:12] == 4'hC || ins[15:12] == 4'hD) && cond_true(ins[11:9], f))});
`endif
    @(posedge clk);
    #1;
    if (sb_exp.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      check_eq(sb_tag.pop_front(), pc_addr_out, sb_exp.pop_front());
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; instruction = 16'h0000; pc_addr_in = 16'h0000;
    flags = 3'b000; branch_reg_addr = 16'h0000;
    @(negedge clk);

    // Reset and first sequential step
    step("reset",     1'b1, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0000);
    step("seq_after", 1'b0, 16'h0000, 16'h0000, 3'b000, 16'h0000, 16'h0002);

    // Relative branch forward, backward, untaken
    step("b_fwd",     1'b0, 16'hC205, 16'h0010, 3'b001, 16'h0000, 16'h001C);
    step("b_bwd",     1'b0, 16'hC3FE, 16'h0010, 3'b001, 16'h0000, 16'h000E);
    step("b_untaken", 1'b0, 16'hC205, 16'h0010, 3'b000, 16'h0000, 16'h0012);

    // Full condition x flags sweep
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        logic [15:0] ins;
        ins = {4'hC, 3'(c), 9'd4};
        step($sformatf("sweep_c%0d_f%0d", c, f), 1'b0, ins, 16'h0100, 3'(f), 16'h0000,
             cond_true(3'(c), 3'(f)) ? 16'h010A : 16'h0102);
      end
    end

    // Register branch
    step("br_uncond",  1'b0, 16'hDE30, 16'h0200, 3'b000, 16'h1234, 16'h1234);
    step("br_odd",     1'b0, 16'hDE30, 16'h0200, 3'b000, 16'h4321, 16'h4321);
    step("br_untaken", 1'b0, 16'hD030, 16'h0200, 3'b001, 16'h1234, 16'h0202);

    // Halt holds, reset overrides halt
    step("hlt_0",     1'b0, 16'hF000, 16'h0040, 3'b111, 16'h1234, 16'h0040);
    step("hlt_1",     1'b0, 16'hF000, 16'h0040, 3'b111, 16'h1234, 16'h0040);
    step("hlt_rst",   1'b1, 16'hF000, 16'h0040, 3'b111, 16'h1234, 16'h0000);
    step("b_rst",     1'b1, 16'hCE05, 16'h0300, 3'b000, 16'h0000, 16'h0000);

    // Address wrap
    step("wrap_seq",  1'b0, 16'h0000, 16'hFFFE, 3'b000, 16'h0000, 16'h0000);
    step("wrap_b",    1'b0, 16'hCE01, 16'hFFFE, 3'b000, 16'h0000, 16'h0002);

    if (sb_exp.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb_exp.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
